// File: rtl/uart_buffer_arbiter_if.sv
// Handshake and buffer-port bundle for uart_buffer_arbiter.
// slave is the arbiter's view; master is the CPU/UART/buffer side.
interface uart_buffer_arbiter_if #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 8
);
  logic                  cpu_req;
  logic                  cpu_release;
  logic                  cpu_grant;
  logic                  tx_start;
  logic [ADDR_WIDTH:0]   tx_len;
  logic                  rx_clear;
  logic [ADDR_WIDTH-1:0] tx_addr;
  logic                  tx_buf_rd;
  logic [DATA_WIDTH-1:0] tx_buf_data;
  logic                  tx_en;
  logic [DATA_WIDTH-1:0] tx_byte;
  logic                  tx_complete;
  logic                  rx_complete;
  logic [ADDR_WIDTH-1:0] rx_addr;
  logic                  rx_buf_wr;
  logic [ADDR_WIDTH:0]   rx_count;
  logic                  rx_full;
  logic                  rx_overrun;
  logic                  busy;
  logic                  irq;

  modport slave (
    input  cpu_req, cpu_release, tx_start, tx_len, rx_clear,
           tx_buf_data, tx_complete, rx_complete,
    output cpu_grant, tx_addr, tx_buf_rd, tx_en, tx_byte,
           rx_addr, rx_buf_wr, rx_count, rx_full, rx_overrun, busy, irq
  );

  modport master (
    output cpu_req, cpu_release, tx_start, tx_len, rx_clear,
           tx_buf_data, tx_complete, rx_complete,
    input  cpu_grant, tx_addr, tx_buf_rd, tx_en, tx_byte,
           rx_addr, rx_buf_wr, rx_count, rx_full, rx_overrun, busy, irq
  );
endinterface

// File: rtl/uart_buffer_arbiter.sv
// Arbitrates the UART Tx/Rx buffers between the CPU and a Tx byte sequencer,
// with free-running Rx capture. Define UART_ARB_IRQ_EN to enable the irq pulse.
module uart_buffer_arbiter #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 8
) (
  input logic                  clock,
  input logic                  reset,
  uart_buffer_arbiter_if.slave bus
);

  localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH+1)'(1 << ADDR_WIDTH);

  typedef enum logic [2:0] {IDLE, CPU_OWN, TX_FETCH, TX_LOAD, TX_WAIT} state_t;

  state_t                state, state_next;
  logic [ADDR_WIDTH-1:0] tx_addr_q, tx_addr_next;
  logic [ADDR_WIDTH:0]   len_q, len_next;
  logic [DATA_WIDTH-1:0] tx_byte_q;
  logic                  tx_en_q;
  logic [ADDR_WIDTH-1:0] rx_addr_q;
  logic [ADDR_WIDTH:0]   rx_count_q;
  logic                  rx_overrun_q;
  logic                  len_ok, more_bytes, rx_full, rx_write, rx_drop;

  assign len_ok     = (bus.tx_len != '0) && (bus.tx_len <= FULL_COUNT);
  assign more_bytes = ({1'b0, tx_addr_q} + (ADDR_WIDTH+1)'(1)) < len_q;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= IDLE;
      tx_addr_q <= '0;
      len_q     <= '0;
    end else begin
      state     <= state_next;
      tx_addr_q <= tx_addr_next;
      len_q     <= len_next;
    end
  end

  // cpu_req is checked before tx_start so the CPU wins a same-cycle tie.
  always_comb begin
    state_next   = state;
    tx_addr_next = tx_addr_q;
    len_next     = len_q;
    case (state)
      IDLE: begin
        if (bus.cpu_req) begin
          state_next = CPU_OWN;
        end else if (bus.tx_start && len_ok) begin
          state_next   = TX_FETCH;
          tx_addr_next = '0;
          len_next     = bus.tx_len;
        end
      end
      CPU_OWN:  if (bus.cpu_release) state_next = IDLE;
      TX_FETCH: state_next = TX_LOAD;
      TX_LOAD:  state_next = TX_WAIT;
      TX_WAIT: begin
        if (bus.tx_complete) begin
          if (more_bytes) begin
            state_next   = TX_FETCH;
            tx_addr_next = tx_addr_q + ADDR_WIDTH'(1);
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Buffer data arrives in TX_LOAD; tx_en rises together with the registered byte.
  always_ff @(posedge clock) begin
    if (!reset) begin
      tx_byte_q <= '0;
      tx_en_q   <= 1'b0;
    end else begin
      tx_en_q <= (state == TX_LOAD);
      if (state == TX_LOAD) tx_byte_q <= bus.tx_buf_data;
    end
  end

  assign rx_full  = (rx_count_q == FULL_COUNT);
  assign rx_write = bus.rx_complete && !rx_full && (state != CPU_OWN);
  assign rx_drop  = bus.rx_complete && !rx_write;

  // rx_addr is one bit narrower than rx_count, so it wraps to 0 as the count hits full.
  always_ff @(posedge clock) begin
    if (!reset) begin
      rx_addr_q    <= '0;
      rx_count_q   <= '0;
      rx_overrun_q <= 1'b0;
    end else if (bus.rx_clear) begin
      rx_addr_q    <= '0;
      rx_count_q   <= '0;
      rx_overrun_q <= 1'b0;
    end else begin
      if (rx_write) begin
        rx_addr_q  <= rx_addr_q + ADDR_WIDTH'(1);
        rx_count_q <= rx_count_q + (ADDR_WIDTH+1)'(1);
      end
      if (rx_drop) rx_overrun_q <= 1'b1;
    end
  end

`ifdef UART_ARB_IRQ_EN
  logic tx_done, irq_q;
  assign tx_done = (state == TX_WAIT) && bus.tx_complete && !more_bytes;

  always_ff @(posedge clock) begin
    if (!reset) irq_q <= 1'b0;
    else        irq_q <= tx_done || rx_write;
  end
  assign bus.irq = irq_q;
`else
  assign bus.irq = 1'b0;
`endif

  assign bus.cpu_grant  = (state == CPU_OWN);
  assign bus.busy       = (state == TX_FETCH) || (state == TX_LOAD) || (state == TX_WAIT);
  assign bus.tx_buf_rd  = (state == TX_FETCH);
  assign bus.tx_addr    = tx_addr_q;
  assign bus.tx_en      = tx_en_q;
  assign bus.tx_byte    = tx_byte_q;
  assign bus.rx_addr    = rx_addr_q;
  assign bus.rx_buf_wr  = rx_write && reset;
  assign bus.rx_count   = rx_count_q;
  assign bus.rx_full    = rx_full;
  assign bus.rx_overrun = rx_overrun_q;

endmodule

// File: tb/tb_uart_buffer_arbiter.sv
// Bench for uart_buffer_arbiter: directed scenarios plus randomized Tx/Rx traffic
// checked against a queue-based model of the buffers and counters.
module tb_uart_buffer_arbiter;
  localparam int AW = 6;
  localparam int DW = 8;

  logic clock = 1'b0;
  logic reset = 1'b0;

  uart_buffer_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
  uart_buffer_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clock(clock), .reset(reset), .bus(bus)
  );

  always #5 clock = ~clock;

  // External Tx buffer with one-cycle read latency.
  logic [DW-1:0] mem [64];
  always @(posedge clock) if (bus.tx_buf_rd) bus.tx_buf_data <= mem[bus.tx_addr];

  // UART transmitter: answers each tx_en with tx_complete ten cycles later.
  logic resp_cmp = 1'b0;
  logic man_cmp  = 1'b0;
  bit   auto_cmp = 1'b1;
  assign bus.tx_complete = resp_cmp | man_cmp;
  always begin
    @(negedge clock);
    if (bus.tx_en && auto_cmp) begin
      repeat (10) @(posedge clock);
      #1 resp_cmp = 1'b1;
      @(posedge clock);
      #1 resp_cmp = 1'b0;
    end
  end

  // Observed traffic, only ever written here.
  logic [DW-1:0] txq [$];
  int            rxq [$];
  int rd_count = 0, irq_pulses = 0, irq_run = 0, irq_max = 0;
  always @(negedge clock) begin
    if (bus.tx_en)     txq.push_back(bus.tx_byte);
    if (bus.rx_buf_wr) rxq.push_back(int'(bus.rx_addr));
    if (bus.tx_buf_rd) rd_count++;
    if (bus.irq) begin
      irq_run++;
      if (irq_run == 1) irq_pulses++;
      if (irq_run > irq_max) irq_max = irq_run;
    end else begin
      irq_run = 0;
    end
  end

  int checks = 0, passed = 0, failed = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Rx model: bytes land at consecutive addresses until 64 are held, then drop as overruns.
  int exp_rx_count = 0;
  bit exp_overrun  = 1'b0;
  int exp_addrs [$];

  task automatic model_rx_byte(input bit granted);
    if (granted || exp_rx_count == 64) begin
      exp_overrun = 1'b1;
    end else begin
      exp_addrs.push_back(exp_rx_count);
      exp_rx_count++;
    end
  endtask

  task automatic model_rx_clear();
    exp_rx_count = 0;
    exp_overrun  = 1'b0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic start_tx(input logic [AW:0] len);
    tick();
    bus.tx_len   = len;
    bus.tx_start = 1'b1;
    tick();
    bus.tx_start = 1'b0;
  endtask

  task automatic rx_pulse(input bit granted);
    tick();
    bus.rx_complete = 1'b1;
    model_rx_byte(granted);
    tick();
    bus.rx_complete = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    @(negedge clock);
    while (bus.busy && n < budget) begin
      @(negedge clock);
      n++;
    end
    check(tag, bus.busy, 0);
  endtask

  task automatic check_tx_bytes(input string tag, input int base, input int len);
    int errs = 0;
    check({tag, "_count"}, txq.size() - base, len);
    for (int unsigned i = 0; i < len; i++)
      if (base + i >= txq.size() || txq[base + i] !== mem[i]) errs++;
    check({tag, "_bytes"}, errs, 0);
  endtask

  task automatic check_rx_state(input string tag);
    check({tag, "_count"}, bus.rx_count, exp_rx_count);
    check({tag, "_overrun"}, bus.rx_overrun, exp_overrun);
    check({tag, "_full"}, bus.rx_full, exp_rx_count == 64);
  endtask

  task automatic grant_and_clear(input string tag);
    tick();
    bus.cpu_req = 1'b1;
    tick();
    @(negedge clock);
    check({tag, "_grant"}, bus.cpu_grant, 1);
    tick();
    bus.rx_clear = 1'b1;
    tick();
    bus.rx_clear = 1'b0;
    model_rx_clear();
    bus.cpu_release = 1'b1;
    bus.cpu_req     = 1'b0;
    tick();
    bus.cpu_release = 1'b0;
    @(negedge clock);
    check({tag, "_released"}, bus.cpu_grant, 0);
    check_rx_state(tag);
  endtask

  initial begin
    int txb, rdb, rxb, irqb, n, errs;
    logic [AW:0] len;

    bus.cpu_req = 1'b0; bus.cpu_release = 1'b0; bus.tx_start = 1'b0;
    bus.tx_len = '0; bus.rx_clear = 1'b0; bus.rx_complete = 1'b0;
    foreach (mem[i]) mem[i] = '0;

    // Reset values
    repeat (3) tick();
    @(negedge clock);
    check("rst_grant", bus.cpu_grant, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_tx_en", bus.tx_en, 0);
    check("rst_tx_addr", bus.tx_addr, 0);
    check("rst_rd", bus.tx_buf_rd, 0);
    check("rst_rx_count", bus.rx_count, 0);
    check("rst_rx_full", bus.rx_full, 0);
    check("rst_rx_overrun", bus.rx_overrun, 0);
    check("rst_irq", bus.irq, 0);
    tick();
    reset = 1'b1;

    // Three-byte transmission
    mem[0] = 8'h41; mem[1] = 8'h42; mem[2] = 8'h43;
    txb = txq.size();
    start_tx(3);
    wait_idle("tx3_done", 200);
    check_tx_bytes("tx3", txb, 3);

    // Out-of-range lengths are ignored
    rdb = rd_count;
    start_tx(0);
    start_tx(65);
    tick();
    @(negedge clock);
    check("badlen_busy", bus.busy, 0);
    check("badlen_rd", rd_count - rdb, 0);

    // CPU request held off until the Tx sequence finishes
    mem[0] = 8'h5a; mem[1] = 8'ha5;
    txb = txq.size();
    start_tx(2);
    tick();
    tick();
    bus.cpu_req = 1'b1;
    n = 0; errs = 0;
    @(negedge clock);
    while (bus.busy && n < 200) begin
      if (bus.cpu_grant) errs++;
      @(negedge clock);
      n++;
    end
    check("holdoff_timeout", bus.busy, 0);
    check("holdoff_grant_during_busy", errs, 0);
    check("holdoff_grant_at_fall", bus.cpu_grant, 0);
    @(negedge clock);
    check("holdoff_grant_after", bus.cpu_grant, 1);
    check_tx_bytes("tx2", txb, 2);
    tick();
    bus.cpu_release = 1'b1;
    bus.cpu_req     = 1'b0;
    @(negedge clock);
    check("release_same_cycle", bus.cpu_grant, 1);
    tick();
    bus.cpu_release = 1'b0;
    @(negedge clock);
    check("release_next_cycle", bus.cpu_grant, 0);

    // Fill the Rx buffer and overrun it
    rxb = rxq.size();
    exp_addrs.delete();
    for (int unsigned i = 0; i < 65; i++) rx_pulse(1'b0);
    @(negedge clock);
    check("rx65_writes", rxq.size() - rxb, 64);
    errs = 0;
    for (int unsigned i = 0; i < 64; i++)
      if (rxb + i >= rxq.size() || rxq[rxb + i] != exp_addrs[i]) errs++;
    check("rx65_addrs", errs, 0);
    check_rx_state("rx65");
    check("rx65_addr_wrap", bus.rx_addr, 0);

    // Under grant: clear, dropped byte, ignored tx_start
    tick();
    bus.cpu_req = 1'b1;
    tick();
    tick();
    bus.rx_clear = 1'b1;
    tick();
    bus.rx_clear = 1'b0;
    model_rx_clear();
    @(negedge clock);
    check_rx_state("gclear");
    check("gclear_rx_addr", bus.rx_addr, 0);
    rxb = rxq.size();
    rx_pulse(1'b1);
    @(negedge clock);
    check("gdrop_writes", rxq.size() - rxb, 0);
    check_rx_state("gdrop");
    rdb = rd_count;
    start_tx(3);
    tick();
    @(negedge clock);
    check("gtx_busy", bus.busy, 0);
    check("gtx_rd", rd_count - rdb, 0);
    check("gtx_grant", bus.cpu_grant, 1);
    tick();
    bus.rx_clear    = 1'b1;
    bus.cpu_release = 1'b1;
    bus.cpu_req     = 1'b0;
    tick();
    bus.rx_clear    = 1'b0;
    bus.cpu_release = 1'b0;
    model_rx_clear();
    @(negedge clock);
    check_rx_state("grel");

    // Simultaneous cpu_req and tx_start: CPU wins
    rdb = rd_count;
    tick();
    bus.cpu_req  = 1'b1;
    bus.tx_start = 1'b1;
    bus.tx_len   = 1;
    tick();
    bus.tx_start = 1'b0;
    @(negedge clock);
    check("tie_grant", bus.cpu_grant, 1);
    check("tie_busy", bus.busy, 0);
    repeat (3) tick();
    check("tie_rd", rd_count - rdb, 0);
    bus.cpu_release = 1'b1;
    bus.cpu_req     = 1'b0;
    tick();
    bus.cpu_release = 1'b0;

    // Reset in the middle of TX_WAIT
    auto_cmp = 1'b0;
    txb = txq.size();
    start_tx(2);
    n = 0;
    @(negedge clock);
    while (txq.size() == txb && n < 50) begin
      @(negedge clock);
      n++;
    end
    check("abort_tx_en_seen", txq.size() - txb, 1);
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    model_rx_clear();
    @(negedge clock);
    check("abort_busy", bus.busy, 0);
    check("abort_tx_addr", bus.tx_addr, 0);
    check("abort_tx_en", bus.tx_en, 0);
    check("abort_grant", bus.cpu_grant, 0);
    check_rx_state("abort");
    rdb = rd_count;
    tick();
    man_cmp = 1'b1;
    tick();
    man_cmp = 1'b0;
    repeat (5) tick();
    @(negedge clock);
    check("abort_late_busy", bus.busy, 0);
    check("abort_late_rd", rd_count - rdb, 0);
    check("abort_late_tx_en", txq.size() - txb, 1);
    auto_cmp = 1'b1;

    // irq: one Tx completion plus one Rx byte
    irqb = irq_pulses;
    start_tx(1);
    wait_idle("irq_tx_done", 100);
    repeat (3) tick();
    rx_pulse(1'b0);
    repeat (3) tick();
    @(negedge clock);
`ifdef UART_ARB_IRQ_EN
    check("irq_pulses", irq_pulses - irqb, 2);
    check("irq_width", irq_max, 1);
`else
    check("irq_pulses", irq_pulses - irqb, 0);
    check("irq_width", irq_max, 0);
`endif
    check_rx_state("irq_rx");

    // Randomized Tx lengths/data with concurrent Rx traffic
    rxb = rxq.size();
    exp_addrs.delete();
    for (int unsigned t = 0; t < 6; t++) begin
      len = (AW+1)'($urandom_range(64, 1));
      for (int unsigned i = 0; i < 64; i++) mem[i] = DW'($urandom);
      txb = txq.size();
      start_tx(len);
      n = 0;
      forever begin
        tick();
        bus.rx_complete = ($urandom_range(3) == 0);
        if (bus.rx_complete) model_rx_byte(1'b0);
        @(negedge clock);
        n++;
        if (!bus.busy || n > 20 * int'(len) + 50) break;
      end
      tick();
      bus.rx_complete = 1'b0;
      @(negedge clock);
      check("rnd_tx_done", bus.busy, 0);
      check_tx_bytes("rnd_tx", txb, int'(len));
      check_rx_state("rnd_rx");
      if ($urandom_range(1) == 1) grant_and_clear("rnd_clear");
    end
    errs = 0;
    for (int unsigned i = 0; i < exp_addrs.size(); i++)
      if (rxb + i >= rxq.size() || rxq[rxb + i] != exp_addrs[i]) errs++;
    check("rnd_rx_writes", rxq.size() - rxb, exp_addrs.size());
    check("rnd_rx_addrs", errs, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/uart_buffer_arbiter.md
UART_BUFFER_ARBITER -- requirements
Module: uart_buffer_arbiter

Interface
REQ-001 The block SHALL take parameter ADDR_WIDTH, default 6, which sets the buffer address width (64 bytes per buffer).
REQ-002 The block SHALL take parameter DATA_WIDTH, default 8, which sets the byte width.
REQ-003 The block SHALL have ports: clock in 1 system clock; reset in 1 synchronous, active-low.
REQ-004 The block SHALL have ports: cpu_req in 1 request buffer ownership (level); cpu_release in 1 release pulse; cpu_grant out 1 CPU owns both buffers.
REQ-005 The block SHALL have ports: tx_start in 1 start pulse; tx_len in ADDR_WIDTH+1 byte count 1..64; rx_clear in 1 reset Rx count pulse.
REQ-006 The block SHALL have ports: tx_addr out ADDR_WIDTH; tx_buf_rd out 1; tx_buf_data in DATA_WIDTH (Tx buffer read port, 1-cycle read latency).
REQ-007 The block SHALL have ports: tx_en out 1; tx_byte out DATA_WIDTH; tx_complete in 1 (UART transmitter handshake).
REQ-008 The block SHALL have ports: rx_complete in 1 byte-received pulse; rx_addr out ADDR_WIDTH; rx_buf_wr out 1 Rx buffer write strobe.
REQ-009 The block SHALL have ports: rx_count out ADDR_WIDTH+1; rx_full out 1; rx_overrun out 1 sticky; busy out 1 Tx sequence active; irq out 1.

Function
REQ-010 The FSM SHALL have states IDLE, CPU_OWN, TX_FETCH, TX_LOAD, TX_WAIT.
REQ-011 In IDLE, cpu_req=1 SHALL enter CPU_OWN and assert cpu_grant from the next cycle; cpu_req has priority over a simultaneous tx_start.
REQ-012 In CPU_OWN, cpu_release SHALL return to IDLE and deassert cpu_grant the next cycle; tx_start SHALL be ignored.
REQ-013 In CPU_OWN, tx_start, rx_clear and tx_len SHALL not modify arbiter state except: rx_clear sets rx_count=0, rx_addr=0 and clears rx_overrun.
REQ-014 In IDLE, tx_start with tx_len in 1..64 SHALL set tx_addr=0, latch tx_len, assert busy, and enter TX_FETCH; tx_len=0 or >64 SHALL be ignored.
REQ-015 TX_FETCH SHALL pulse tx_buf_rd for one cycle and enter TX_LOAD.
REQ-016 TX_LOAD SHALL register tx_buf_data into tx_byte, pulse tx_en for one cycle, and enter TX_WAIT.
REQ-017 In TX_WAIT, tx_complete SHALL increment tx_addr and enter TX_FETCH if bytes remain, otherwise enter IDLE and deassert busy.
REQ-018 A cpu_req arriving while busy SHALL be held off; the grant SHALL follow only after the sequence returns to IDLE.
REQ-019 When not in CPU_OWN, rx_complete with rx_full=0 SHALL pulse rx_buf_wr at the current rx_addr that cycle, and rx_addr and rx_count SHALL increment on the following edge.
REQ-020 rx_full SHALL equal (rx_count==64); rx_addr SHALL wrap to 0 when rx_count reaches 64.
REQ-021 rx_complete while rx_full=1 or in CPU_OWN SHALL drop the byte, set rx_overrun, and issue no write.
REQ-022 Rx capture SHALL run concurrently with a Tx sequence; both address counters are independent.

Reset
REQ-023 With reset=0 at a clock edge, the block SHALL enter IDLE and drive all outputs to 0, including a mid-sequence abort with no further tx_en.

Configuration
REQ-024 With macro UART_ARB_IRQ_EN defined, irq SHALL pulse one cycle on Tx sequence completion and on each successful Rx write; without it, irq SHALL be tied to 0.

Verification
REQ-025 Bench: tx_start with tx_len=3 and buffer holding 0x41,0x42,0x43, tx_complete returned 10 cycles after each tx_en -> three tx_en pulses with tx_byte 0x41,0x42,0x43, then busy=0.
REQ-026 Bench: cpu_req asserted mid-Tx of len 2 -> cpu_grant stays 0 until the cycle after busy falls, then 1; cpu_release -> cpu_grant 0 the next cycle.
REQ-027 Bench: 65 rx_complete pulses -> 64 rx_buf_wr at addresses 0..63, then rx_full=1, rx_overrun=1; rx_clear under grant -> rx_count=0, rx_overrun=0.
REQ-028 Bench: cpu_req and tx_start in the same IDLE cycle -> cpu_grant=1 and no tx_buf_rd.
REQ-029 Bench: reset=0 during TX_WAIT -> IDLE next cycle, busy=0, tx_addr=0, and a later tx_complete is ignored.
REQ-030 Bench with UART_ARB_IRQ_EN: a len=1 Tx plus one Rx byte -> exactly two single-cycle irq pulses; without the macro, irq stays 0.
